// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive blocks.
//   - uart_state_e        : frame-sequencer state encoding
//   - UART_CLKS_PER_BIT   : default clock cycles per serial bit
//   - UART_DATA_W         : data bits per frame
//   - UART_IDX_W          : width of the data-bit index
//   - even_parity()       : parity bit that makes the count of ones even
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 9600;
  localparam int UART_DATA_W       = 8;
  localparam int UART_IDX_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity over one data word: XOR of all bits.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. While en is high it counts 0 .. CLKS_PER_BIT-1 and
// wraps; bit_tick is high for the single cycle in which the count equals
// CLKS_PER_BIT-1, i.e. the last cycle of the current bit. While en is low the
// count is held at 0 so every bit period starts from a clean phase.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   en       in   count enable (high while a frame is on the line)
//   bit_tick out  last-cycle-of-bit strobe
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Bit-period counter: cleared when idle, wraps at the last cycle of a bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (!en) begin
      cnt_r <= CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Decoded from the counter register only, so it is glitch-free.
  assign bit_tick = en && (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial transmitter: 1 start bit, 8 data bits LSB first, optional even
// parity bit, 1 stop bit. Each bit lasts CLKS_PER_BIT clocks.
// A byte is accepted on a rising edge with tx_valid && tx_ready; the line
// drops to the start bit on the following cycle. tx_ready is high only in
// IDLE, so consecutive frames are always separated by at least one
// idle-high cycle, and tx_valid while busy is simply ignored.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (aborts a frame)
//   tx_data    in   byte offered for transmission
//   tx_valid   in   tx_data is valid
//   tx_ready   out  block accepts a byte this cycle (registered)
//   tx         out  serial line, idle high (registered)
//   busy       out  high from first start-bit cycle to last stop-bit cycle
//   frame_done out  one-cycle pulse on the last stop-bit cycle
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [UART_IDX_W-1:0] IDX_ZERO = {UART_IDX_W{1'b0}};
  localparam logic [UART_IDX_W-1:0] IDX_ONE  = UART_IDX_W'(1);
  localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(UART_DATA_W - 1);

  uart_state_e            state_r;
  uart_state_e            next_state_s;
  logic [UART_DATA_W-1:0] data_r;
  logic [UART_IDX_W-1:0]  idx_r;
  logic                   tx_r;
  logic                   tx_next_s;
  logic                   busy_r;
  logic                   ready_r;
  logic                   accept_s;
  logic                   bit_tick_s;

  // The bit timer only runs while a frame is on the line.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (busy_r),
    .bit_tick(bit_tick_s)
  );

  // Next-state and next-line-value decode. The line value for the next bit
  // is chosen at the same edge the state advances, so tx stays registered
  // with no extra latency between state and line.
  always_comb begin
    next_state_s = state_r;
    tx_next_s    = tx_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tx_next_s = 1'b1;
        if (tx_valid && ready_r) begin
          accept_s     = 1'b1;
          next_state_s = ST_START;
          tx_next_s    = 1'b0;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_tick_s) begin
          next_state_s = ST_DATA;
          tx_next_s    = data_r[0];
        end else begin
          next_state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_tick_s) begin
          if (idx_r == IDX_LAST) begin
            if (PARITY_EN == 1) begin
              next_state_s = ST_PARITY;
              tx_next_s    = even_parity(data_r);
            end else begin
              next_state_s = ST_STOP;
              tx_next_s    = 1'b1;
            end
          end else begin
            next_state_s = ST_DATA;
            tx_next_s    = data_r[idx_r + IDX_ONE];
          end
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_tick_s) begin
          next_state_s = ST_STOP;
          tx_next_s    = 1'b1;
        end else begin
          next_state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        tx_next_s = 1'b1;
        if (bit_tick_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_STOP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        tx_next_s    = 1'b1;
      end
    endcase
  end

  // State register and registered line/handshake outputs. ready and busy
  // are derived from the next state so they line up exactly with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      tx_r    <= 1'b1;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      tx_r    <= tx_next_s;
      ready_r <= (next_state_s == ST_IDLE);
      busy_r  <= (next_state_s != ST_IDLE);
    end
  end

  // Data latch: captured only at acceptance, so tx_data may change freely
  // while the frame is being sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= {UART_DATA_W{1'b0}};
    end else if (accept_s) begin
      data_r <= tx_data;
    end else begin
      data_r <= data_r;
    end
  end

  // Data-bit index: advances at the end of each data bit and wraps back to
  // 0 after bit 7, which leaves it ready for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= IDX_ZERO;
    end else if (accept_s) begin
      idx_r <= IDX_ZERO;
    end else if ((state_r == ST_DATA) && bit_tick_s) begin
      idx_r <= idx_r + IDX_ONE;
    end else begin
      idx_r <= idx_r;
    end
  end

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign tx_ready   = ready_r;
  // AND of two register-driven terms: high only on the last stop-bit cycle.
  assign frame_done = (state_r == ST_STOP) && bit_tick_s;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Two transmitters (no parity / even parity, 4 clocks per bit) are driven by
// directed and random stimulus. A frame-position reference model predicts the
// line, busy, ready and frame_done every cycle and pushes each accepted byte
// into a scoreboard queue; a serial decoder samples the line at bit centres
// and, on every frame_done, pops the queue and compares the decoded frame.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] tx_valid;
  logic [7:0] tx_data [2];
  logic [1:0] tx_ready;
  logic [1:0] txl;
  logic [1:0] busy;
  logic [1:0] fdone;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx(txl[0]), .busy(busy[0]), .frame_done(fdone[0])
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx(txl[1]), .busy(busy[1]), .frame_done(fdone[1])
  );

  // ---------------- reference model ----------------
  int         m_pos [2];   // -1 idle, else cycle index within the frame
  bit         m_ready [2];
  logic [7:0] m_byte [2];
  int         m_acc [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  function automatic int flen(input int p);
    return (10 + p) * CPB;
  endfunction

  function automatic int ones(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) n += (b >> i) & 1;
    return n;
  endfunction

  // Line level of frame bit k: start, d0..d7, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] b, input int pe, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return ((b >> (k - 1)) & 8'd1) != 8'd0;
    if (pe != 0 && k == 9) return (ones(b) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic check(input string name, input int p, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[p%0d] @%0t: got %0h, expected %0h", name, p, $time, act, exp);
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      m_pos[p] = -1; m_ready[p] = 1'b0; m_acc[p] = 0; m_byte[p] = 8'h00;
    end
    forever begin
      @(posedge clk);
      for (int p = 0; p < 2; p++) begin
        if (rst[p]) begin
          m_pos[p] = -1; m_ready[p] = 1'b0;
          if (p == 0) q0.delete(); else q1.delete();
        end else if (m_pos[p] >= 0) begin
          m_pos[p]++;
          if (m_pos[p] == flen(p)) begin
            m_pos[p] = -1; m_ready[p] = 1'b1;
          end
        end else if (m_ready[p] && tx_valid[p]) begin
          m_pos[p] = 0; m_ready[p] = 1'b0; m_byte[p] = tx_data[p]; m_acc[p]++;
          if (p == 0) q0.push_back(tx_data[p]); else q1.push_back(tx_data[p]);
        end else begin
          m_ready[p] = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor / decoder / scoreboard ----------------
  bit   dec_act [2];
  int   dec_cnt [2];
  logic dec_bits [2][12];

  initial begin
    logic [7:0] exp_b;
    logic [7:0] got_b;
    int         qn;
    dec_act[0] = 1'b0; dec_act[1] = 1'b0; dec_cnt[0] = 0; dec_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        check("tx", p, txl[p], (m_pos[p] < 0) ? 1'b1 : frame_bit(m_byte[p], p, m_pos[p] / CPB));
        check("busy", p, busy[p], m_pos[p] >= 0);
        check("tx_ready", p, tx_ready[p], m_ready[p]);
        check("frame_done", p, fdone[p], m_pos[p] == flen(p) - 1);
        if (rst[p]) begin
          dec_act[p] = 1'b0;
        end else begin
          if (!dec_act[p] && txl[p] == 1'b0) begin
            dec_act[p] = 1'b1; dec_cnt[p] = 0;
          end else if (dec_act[p]) begin
            dec_cnt[p]++;
          end
          if (dec_act[p] && (dec_cnt[p] % CPB) == CPB / 2 && dec_cnt[p] / CPB < 12)
            dec_bits[p][dec_cnt[p] / CPB] = txl[p];
          if (fdone[p]) begin
            qn = (p == 0) ? q0.size() : q1.size();
            check("sb_nonempty", p, qn > 0, 1'b1);
            if (qn > 0) begin
              exp_b = (p == 0) ? q0.pop_front() : q1.pop_front();
              got_b = 8'h00;
              for (int i = 0; i < 8; i++) got_b[i] = dec_bits[p][i + 1];
              check("rx_start", p, dec_bits[p][0], 1'b0);
              check("rx_byte", p, got_b, exp_b);
              if (p == 1) check("rx_parity", p, dec_bits[p][9], (ones(exp_b) % 2) == 1);
              check("rx_stop", p, dec_bits[p][9 + p], 1'b1);
              check("frame_len", p, dec_cnt[p] + 1, flen(p));
            end
            dec_act[p] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int p, input logic [7:0] b, input bit hold);
    int a0;
    int t;
    a0 = m_acc[p];
    t = 0;
    tx_valid[p] = 1'b1;
    tx_data[p]  = b;
    do begin
      tick();
      t++;
    end while (m_acc[p] == a0 && t < 1000);
    check("accept", p, m_acc[p] - a0, 1);
    if (!hold) tx_valid[p] = 1'b0;
    tx_data[p] = 8'($urandom);
  endtask

  task automatic wait_idle(input int p);
    int t;
    t = 0;
    while ((m_pos[p] >= 0 || !m_ready[p]) && t < 2000) begin
      if (!tx_valid[p]) tx_data[p] = 8'($urandom);
      tick();
      t++;
    end
    check("idle_reached", p, m_pos[p] < 0, 1'b1);
  endtask

  initial begin
    int t;
    int p;
    int n;
    rst = 2'b11; tx_valid = 2'b00; tx_data[0] = 8'h00; tx_data[1] = 8'h00;
    repeat (3) tick();
    rst = 2'b00;
    tick();

    // single byte, no parity, then parity frames
    send(0, 8'hA5, 1'b0); wait_idle(0);
    send(1, 8'hA5, 1'b0); wait_idle(1);
    send(1, 8'h01, 1'b0); wait_idle(1);

    // back-to-back with tx_valid held high
    send(0, 8'h55, 1'b1); send(0, 8'hAA, 1'b0); wait_idle(0);

    // tx_valid pulse mid-frame must be ignored
    send(0, 8'h3E, 1'b0);
    repeat (10) tick();
    tx_valid[0] = 1'b1; tx_data[0] = 8'hFF;
    tick();
    tx_valid[0] = 1'b0;
    wait_idle(0);
    repeat (6) tick();

    // reset during data bit 3, then a clean frame
    send(0, 8'hC3, 1'b0);
    t = 0;
    while (m_pos[0] != 4 * CPB + 1 && t < 200) begin tick(); t++; end
    check("reach_bit3", 0, m_pos[0], 4 * CPB + 1);
    rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    wait_idle(0);
    send(0, 8'h3C, 1'b0); wait_idle(0);

    // loopback bytes on both variants
    for (int k = 0; k < 2; k++) begin
      send(k, 8'h00, 1'b0); wait_idle(k);
      send(k, 8'hFF, 1'b0); wait_idle(k);
      send(k, 8'h5A, 1'b0); wait_idle(k);
    end

    // random traffic with random (sometimes ignored) valid pulses
    for (int i = 0; i < 30; i++) begin
      p = i % 2;
      send(p, 8'($urandom), 1'b0);
      n = $urandom_range(0, 50);
      repeat (n) begin
        if ($urandom_range(0, 7) == 0) begin
          tx_valid[p] = 1'b1; tx_data[p] = 8'($urandom);
        end else begin
          tx_valid[p] = 1'b0;
        end
        tick();
      end
      tx_valid[p] = 1'b0;
    end
    wait_idle(0);
    wait_idle(1);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
